// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: phase encodings,
// default phase durations and the default board clock frequency.
package traffic_pkg;

    // Phase encodings (3 bits)
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GREEN  = 3'd1;
    localparam logic [2:0] YELLOW = 3'd2;
    localparam logic [2:0] RED    = 3'd3;
    localparam logic [2:0] WALK   = 3'd4;
    localparam logic [2:0] NIGHT  = 3'd5;

    // Default timing
    localparam int DEF_CLK_HZ   = 50_000_000;
    localparam int DEF_GREEN_S  = 10;
    localparam int DEF_YELLOW_S = 3;
    localparam int DEF_RED_S    = 5;
    localparam int DEF_WALK_S   = 8;
    localparam int DEF_CNT_W    = 5;

endpackage

// File: rtl/phase_timer_tick_gen.sv
// tick_gen: free-running prescaler 0..CLK_HZ-1 with a synchronous clear.
// tick marks the last cycle of each second; half_tick also marks the last
// cycle of the first half-second.
module tick_gen
    import traffic_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick,
    output logic half_tick
);

    localparam int PW = $clog2(CLK_HZ);

    logic [PW-1:0] cnt;

    assign tick      = (cnt == PW'(CLK_HZ - 1));
    assign half_tick = tick || (cnt == PW'(CLK_HZ / 2 - 1));

    // Prescaler: restart on clear, wrap after the last cycle of a second
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/phase_timer.sv
// phase_timer: decodes the light FSM outputs into a phase, times each phase
// in whole seconds and returns a one-cycle done pulse on expiry. Also drives
// the seconds countdown for the display and the night-mode blink.
// Optional walk beeper: define PHASE_TIMER_BEEP_EN to build it; otherwise
// beep is tied low.
//
// phase  | meaning
// IDLE   | no light active, nothing timed
// GREEN  | green light, timed
// YELLOW | yellow light, timed
// RED    | red light, timed
// WALK   | pedestrian walk (red also lit), timed
// NIGHT  | night mode, untimed, blink_out runs at 1 Hz
module phase_timer
    import traffic_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int GREEN_S  = DEF_GREEN_S,
    parameter int YELLOW_S = DEF_YELLOW_S,
    parameter int RED_S    = DEF_RED_S,
    parameter int WALK_S   = DEF_WALK_S,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             green_led,
    input  logic             yellow_led,
    input  logic             red_led,
    input  logic             walk_enable,
    input  logic             blink_enable,
    output logic             green_done,
    output logic             yellow_done,
    output logic             red_done,
    output logic             walk_done,
    output logic [CNT_W-1:0] seconds_left,
    output logic             blink_out,
    output logic             beep
);

    logic [2:0]       decode;
    logic [2:0]       phase_q;
    logic             phase_chg;
    logic [CNT_W-1:0] load_val;
    logic             timed;
    logic             expire_now;
    logic             expired;
    logic             tick;
    logic             half_tick;

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (phase_chg),
        .tick      (tick),
        .half_tick (half_tick)
    );

    // Priority decode of the FSM outputs; walk overrides the red that accompanies it
    always_comb begin
        decode = IDLE;
        if (walk_enable)       decode = WALK;
        else if (blink_enable) decode = NIGHT;
        else if (green_led)    decode = GREEN;
        else if (yellow_led)   decode = YELLOW;
        else if (red_led)      decode = RED;
    end

    // Duration to load on entry, and expiry detection for the current phase
    always_comb begin
        load_val = '0;
        case (decode)
            GREEN:   load_val = CNT_W'(GREEN_S);
            YELLOW:  load_val = CNT_W'(YELLOW_S);
            RED:     load_val = CNT_W'(RED_S);
            WALK:    load_val = CNT_W'(WALK_S);
            default: load_val = '0;
        endcase
        phase_chg  = (decode != phase_q);
        timed      = (phase_q == GREEN) || (phase_q == YELLOW) ||
                     (phase_q == RED)   || (phase_q == WALK);
        expire_now = timed && !phase_chg && tick && !expired &&
                     (seconds_left == CNT_W'(1));
    end

    // Phase register, countdown, done pulses and night blink; a phase change beats a tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= IDLE;
            seconds_left <= '0;
            expired      <= 1'b0;
            green_done   <= 1'b0;
            yellow_done  <= 1'b0;
            red_done     <= 1'b0;
            walk_done    <= 1'b0;
            blink_out    <= 1'b0;
        end else begin
            green_done  <= 1'b0;
            yellow_done <= 1'b0;
            red_done    <= 1'b0;
            walk_done   <= 1'b0;
            if (phase_chg) begin
                phase_q      <= decode;
                seconds_left <= load_val;
                expired      <= 1'b0;
                blink_out    <= 1'b0;
            end else begin
                if (expire_now) begin
                    seconds_left <= '0;
                    expired      <= 1'b1;
                    case (phase_q)
                        GREEN:   green_done  <= 1'b1;
                        YELLOW:  yellow_done <= 1'b1;
                        RED:     red_done    <= 1'b1;
                        WALK:    walk_done   <= 1'b1;
                        default: ;
                    endcase
                end else if (timed && tick && !expired &&
                             (seconds_left > CNT_W'(1))) begin
                    seconds_left <= seconds_left - CNT_W'(1);
                end
                if ((phase_q == NIGHT) && half_tick) begin
                    blink_out <= ~blink_out;
                end
            end
        end
    end

`ifdef PHASE_TIMER_BEEP_EN
    // Walk beeper: high in the first half of every second until the walk expires
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beep <= 1'b0;
        end else if (phase_chg) begin
            beep <= (decode == WALK);
        end else if ((phase_q == WALK) && !expired) begin
            if (tick) begin
                beep <= !expire_now;
            end else if (half_tick) begin
                beep <= 1'b0;
            end
        end else begin
            beep <= 1'b0;
        end
    end
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_phase_timer.sv
// Testbench for phase_timer with CLK_HZ=4, GREEN_S=3, YELLOW_S=2, RED_S=2,
// WALK_S=3. A vector table walks the green/yellow/red/walk/night phases;
// hand-written sequences cover tick-coincident phase change and mid-phase reset.
module tb_phase_timer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       green_led, yellow_led, red_led, walk_enable, blink_enable;
    logic       green_done, yellow_done, red_done, walk_done;
    logic [4:0] seconds_left;
    logic       blink_out, beep;

    int checks = 0;
    int errors = 0;

    int n_g = 0, n_y = 0, n_r = 0, n_w = 0, n_multi = 0, n_beep = 0;

`ifdef PHASE_TIMER_BEEP_EN
    localparam int BEEP_EXP = 6;
`else
    localparam int BEEP_EXP = 0;
`endif

    phase_timer #(
        .CLK_HZ   (4),
        .GREEN_S  (3),
        .YELLOW_S (2),
        .RED_S    (2),
        .WALK_S   (3),
        .CNT_W    (5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .green_led    (green_led),
        .yellow_led   (yellow_led),
        .red_led      (red_led),
        .walk_enable  (walk_enable),
        .blink_enable (blink_enable),
        .green_done   (green_done),
        .yellow_done  (yellow_done),
        .red_done     (red_done),
        .walk_done    (walk_done),
        .seconds_left (seconds_left),
        .blink_out    (blink_out),
        .beep         (beep)
    );

    always #5 clk = ~clk;

    // Pulse, overlap and beep-cycle counters sampled mid-cycle
    always @(negedge clk) begin
        if (green_done)  n_g++;
        if (yellow_done) n_y++;
        if (red_done)    n_r++;
        if (walk_done)   n_w++;
        if ((int'(green_done) + int'(yellow_done) + int'(red_done) + int'(walk_done)) > 1) n_multi++;
        if (beep) n_beep++;
    end

    typedef struct {
        logic [4:0] in;    // {green, yellow, red, walk, blink}
        int         adv;
        int         sec;
        logic [3:0] done;  // {green, yellow, red, walk}
        logic       blink;
        string      name;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] v);
        {green_led, yellow_led, red_led, walk_enable, blink_enable} = v;
    endtask

    task automatic chk_all(input string nm, input int sec, input logic [3:0] done, input logic blink);
        chk({nm, ".sec"}, int'(seconds_left), sec);
        chk({nm, ".done"}, int'({green_done, yellow_done, red_done, walk_done}), int'(done));
        chk({nm, ".blink"}, int'(blink_out), int'(blink));
    endtask

    initial begin
        tbl[0]  = '{5'b00000, 1,  0, 4'b0000, 1'b0, "idle"};
        tbl[1]  = '{5'b10000, 1,  3, 4'b0000, 1'b0, "g_load"};
        tbl[2]  = '{5'b10000, 3,  3, 4'b0000, 1'b0, "g_e3"};
        tbl[3]  = '{5'b10000, 1,  2, 4'b0000, 1'b0, "g_e4"};
        tbl[4]  = '{5'b10000, 4,  1, 4'b0000, 1'b0, "g_e8"};
        tbl[5]  = '{5'b10000, 3,  1, 4'b0000, 1'b0, "g_e11"};
        tbl[6]  = '{5'b10000, 1,  0, 4'b1000, 1'b0, "g_done"};
        tbl[7]  = '{5'b10000, 1,  0, 4'b0000, 1'b0, "g_after"};
        tbl[8]  = '{5'b10000, 20, 0, 4'b0000, 1'b0, "g_hold"};
        tbl[9]  = '{5'b01000, 1,  2, 4'b0000, 1'b0, "y_load"};
        tbl[10] = '{5'b01000, 8,  0, 4'b0100, 1'b0, "y_done"};
        tbl[11] = '{5'b01000, 1,  0, 4'b0000, 1'b0, "y_after"};
        tbl[12] = '{5'b00100, 1,  2, 4'b0000, 1'b0, "r_load"};
        tbl[13] = '{5'b00100, 7,  1, 4'b0000, 1'b0, "r_e7"};
        tbl[14] = '{5'b00100, 1,  0, 4'b0010, 1'b0, "r_done"};
        tbl[15] = '{5'b00100, 1,  0, 4'b0000, 1'b0, "r_after"};
        tbl[16] = '{5'b00110, 1,  3, 4'b0000, 1'b0, "w_load"};
        tbl[17] = '{5'b00110, 11, 1, 4'b0000, 1'b0, "w_e11"};
        tbl[18] = '{5'b00110, 1,  0, 4'b0001, 1'b0, "w_done"};
        tbl[19] = '{5'b00110, 1,  0, 4'b0000, 1'b0, "w_after"};
        tbl[20] = '{5'b00001, 1,  0, 4'b0000, 1'b0, "n_e0"};
        tbl[21] = '{5'b00001, 1,  0, 4'b0000, 1'b0, "n_e1"};
        tbl[22] = '{5'b00001, 1,  0, 4'b0000, 1'b1, "n_e2"};
        tbl[23] = '{5'b00001, 2,  0, 4'b0000, 1'b0, "n_e4"};
        tbl[24] = '{5'b00001, 2,  0, 4'b0000, 1'b1, "n_e6"};
        tbl[25] = '{5'b00001, 34, 0, 4'b0000, 1'b0, "n_e40"};
        tbl[26] = '{5'b10000, 1,  3, 4'b0000, 1'b0, "n_to_g"};

        reset_n = 1'b0;
        set_in(5'b00000);
        step(3);
        chk_all("reset", 0, 4'b0000, 1'b0);
        chk("reset.beep", int'(beep), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            set_in(tbl[i].in);
            step(tbl[i].adv);
            chk_all(tbl[i].name, tbl[i].sec, tbl[i].done, tbl[i].blink);
            if (i == 19) begin
                chk("walk_beep_cycles", n_beep, BEEP_EXP);
            end
        end

        chk("green_pulses", n_g, 1);
        chk("yellow_pulses", n_y, 1);
        chk("red_pulses", n_r, 1);
        chk("walk_pulses", n_w, 1);

        // Green at sec=1 switches to yellow in the tick cycle
        step(11);
        chk("tick_pre.sec", int'(seconds_left), 1);
        set_in(5'b01000);
        step(1);
        chk_all("tick_chg", 2, 4'b0000, 1'b0);
        step(3);
        chk("tick_chg.e3", int'(seconds_left), 2);
        step(1);
        chk("tick_chg.e4", int'(seconds_left), 1);
        step(4);
        chk_all("tick_chg.ydone", 0, 4'b0100, 1'b0);
        chk("tick_chg.gpulses", n_g, 1);

        // Phase change while yellow_done is high clears it; then reset mid-green
        set_in(5'b10000);
        step(1);
        chk_all("chg_clears_done", 3, 4'b0000, 1'b0);
        step(8);
        chk("rst_pre.sec", int'(seconds_left), 1);
        #1 reset_n = 1'b0;
        #1;
        chk_all("rst_async", 0, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step(1);
        chk_all("rst_reload", 3, 4'b0000, 1'b0);
        step(11);
        chk_all("rst_e11", 1, 4'b0000, 1'b0);
        step(1);
        chk_all("rst_gdone", 0, 4'b1000, 1'b0);
        step(1);
        chk_all("rst_after", 0, 4'b0000, 1'b0);

        chk("green_pulses_end", n_g, 2);
        chk("done_overlap", n_multi, 0);
        chk("beep_cycles_end", n_beep, BEEP_EXP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
